// File: rtl/syndrome_loader_pkg.sv
// syndrome_loader_pkg
//   Shared types and constant functions for the syndrome stream loader and
//   its benches: loader FSM state encoding, derived widths (PU_COUNT and
//   payload words per round) and the (i,j,k) -> vector bit mapping.
package syndrome_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Number of processing units (syndrome bits) in one round.
  function automatic int calc_pu_count(input int dx, input int dz, input int rounds);
    return dx * dz * rounds;
  endfunction

  // Payload words needed to carry pu bits in w-bit words (ceiling divide).
  function automatic int calc_words(input int pu, input int w);
    return (pu + w - 1) / w;
  endfunction

  // Bit position of syndrome (i,j,k) inside is_error_syndromes.
  function automatic int index_of(input int i, input int j, input int k,
                                  input int dx, input int dz);
    return i * dz + j + k * dz * dx;
  endfunction

endpackage

// File: rtl/masked_popcount.sv
// masked_popcount
//   Combinational popcount of W data bits, counting only bits whose mask bit
//   is set.
//   Ports:
//     i_data  [W-1:0]  word to count
//     i_mask  [W-1:0]  1 = bit participates
//     o_count [CW-1:0] number of set, unmasked bits
module masked_popcount #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  input  logic [W-1:0]  i_mask,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int b = 0; b < W; b++) begin
      o_count = o_count + CW'(i_data[b] & i_mask[b]);
    end
  end

endmodule

// File: rtl/syndrome_stream_loader.sv
// syndrome_stream_loader
//   Feeds the left/right stage-controller decoder pair. Takes a valid/ready
//   word stream where each round is one header word (test ID) followed by
//   WORDS_PER_ROUND packed syndrome words, builds the PU_COUNT-bit syndrome
//   vector, pulses new_round_start, then holds the vector until the decoder
//   reports result_valid or deadlock and signals round_done.
//
//   Build option: SYNDROME_LOADER_ZERO_SKIP_EN -- when defined, a round whose
//   syndrome_count is zero never reaches the decoder; it finishes straight
//   from LOAD into DONE.
//
//   Ports:
//     clk, reset_n         clock, asynchronous active-low reset
//     s_data/s_valid/s_ready  input word stream
//     is_error_syndromes   syndrome vector to decoder
//     new_round_start      one-cycle start pulse to decoder
//     result_valid, deadlock  decoder completion status
//     round_done           one-cycle pulse at end of round
//     round_deadlock       with round_done: round ended by deadlock
//     test_id              header of current round
//     syndrome_count       popcount of loaded vector
//     busy                 header accept through round_done
module syndrome_stream_loader
  import syndrome_loader_pkg::*;
#(
  parameter int CODE_DISTANCE_X    = 3,
  parameter int CODE_DISTANCE_Z    = 2,
  parameter int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                     CODE_DISTANCE_X : CODE_DISTANCE_Z,
  parameter int PU_COUNT           = calc_pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z,
                                                   MEASUREMENT_ROUNDS),
  parameter int IN_WIDTH           = 32,
  parameter int WORDS_PER_ROUND    = calc_words(PU_COUNT, IN_WIDTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [PU_COUNT-1:0] is_error_syndromes,
  output logic                new_round_start,
  input  logic                result_valid,
  input  logic                deadlock,
  output logic                round_done,
  output logic                round_deadlock,
  output logic [31:0]         test_id,
  output logic [15:0]         syndrome_count,
  output logic                busy
);

  localparam int WCW = $clog2(WORDS_PER_ROUND + 1);
  localparam int PCW = $clog2(IN_WIDTH + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_ROUND - 1);

  state_t              r_state;
  logic [WCW-1:0]      r_word;
  logic                r_ready;
  logic [PU_COUNT-1:0] r_vec;
  logic                r_nrs;
  logic                r_done;
  logic                r_dlk;
  logic [31:0]         r_tid;
  logic [15:0]         r_cnt;
  logic                r_busy;
  logic                r_lvl_q;

  logic [IN_WIDTH-1:0] w_mask;
  logic [PU_COUNT-1:0] w_vec_next;
  logic [PCW-1:0]      w_pc;
  logic [16:0]         w_sum;
  logic [15:0]         w_cnt_next;
  logic                w_accept;
  logic                w_lvl;
  logic                w_rise;

  // Bits of the current payload word that land inside the vector; the tail
  // of the final word is padding and must not be stored or counted.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < IN_WIDTH; b++) begin
      w_mask[b] = ((int'(r_word) * IN_WIDTH + b) < PU_COUNT);
    end
  end

  always_comb begin
    w_vec_next = r_vec;
    for (int p = 0; p < PU_COUNT; p++) begin
      if ((p / IN_WIDTH) == int'(r_word)) w_vec_next[p] = s_data[p % IN_WIDTH];
    end
  end

  masked_popcount #(.W(IN_WIDTH), .CW(PCW)) u_popcount (
    .i_data  (s_data),
    .i_mask  (w_mask),
    .o_count (w_pc)
  );

  assign w_sum      = {1'b0, r_cnt} + 17'(w_pc);
  assign w_cnt_next = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign w_accept   = s_valid & r_ready;

  // The completion level is sampled every cycle, so a level that is still
  // high from the previous round is already in r_lvl_q when WAIT begins and
  // cannot be mistaken for a fresh edge; only a genuine 0->1 transition while
  // the round is outstanding completes it.
  assign w_lvl  = result_valid | deadlock;
  assign w_rise = w_lvl & ~r_lvl_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_ready <= 1'b0;
      r_vec   <= '0;
      r_nrs   <= 1'b0;
      r_done  <= 1'b0;
      r_dlk   <= 1'b0;
      r_tid   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_lvl_q <= 1'b0;
    end else begin
      r_nrs   <= 1'b0;
      r_done  <= 1'b0;
      r_dlk   <= 1'b0;
      r_lvl_q <= w_lvl;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_tid   <= 32'(s_data);
            r_vec   <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_vec  <= w_vec_next;
            r_cnt  <= w_cnt_next;
            r_word <= r_word + 1'b1;
            if (r_word == LAST_WORD) begin
              r_ready <= 1'b0;
              r_word  <= '0;
`ifdef SYNDROME_LOADER_ZERO_SKIP_EN
              if (w_cnt_next == 16'd0) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_DONE;
              end else begin
                r_nrs   <= 1'b1;
                r_state <= ST_START;
              end
`else
              r_nrs   <= 1'b1;
              r_state <= ST_START;
`endif
            end
          end
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_rise) begin
            r_done  <= 1'b1;
            r_dlk   <= deadlock;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready            = r_ready;
  assign is_error_syndromes = r_vec;
  assign new_round_start    = r_nrs;
  assign round_done         = r_done;
  assign round_deadlock     = r_dlk;
  assign test_id            = r_tid;
  assign syndrome_count     = r_cnt;
  assign busy               = r_busy;

endmodule

// File: tb/tb_syndrome_stream_loader.sv
// tb_syndrome_stream_loader
//   Two loaders (32-bit and 8-bit stream words, d=3 -> 18 syndrome bits).
//   The 32-bit one runs a table of fixed rounds; the 8-bit one runs
//   hand-written corner sequences and randomized rounds whose expected vector
//   is built from randomly chosen (i,j,k) syndrome coordinates.
module tb_syndrome_stream_loader;
  import syndrome_loader_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [31:0] a_data;  logic a_valid, a_ready;
  logic [17:0] a_vec;   logic a_nrs, a_rv, a_dl, a_done, a_dlk, a_busy;
  logic [31:0] a_tid;   logic [15:0] a_cnt;

  logic [7:0]  b_data;  logic b_valid, b_ready;
  logic [17:0] b_vec;   logic b_nrs, b_rv, b_dl, b_done, b_dlk, b_busy;
  logic [31:0] b_tid;   logic [15:0] b_cnt;

  syndrome_stream_loader #(.IN_WIDTH(32)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
    .is_error_syndromes(a_vec), .new_round_start(a_nrs), .result_valid(a_rv),
    .deadlock(a_dl), .round_done(a_done), .round_deadlock(a_dlk), .test_id(a_tid),
    .syndrome_count(a_cnt), .busy(a_busy));

  syndrome_stream_loader #(.IN_WIDTH(8)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
    .is_error_syndromes(b_vec), .new_round_start(b_nrs), .result_valid(b_rv),
    .deadlock(b_dl), .round_done(b_done), .round_deadlock(b_dlk), .test_id(b_tid),
    .syndrome_count(b_cnt), .busy(b_busy));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic a_send(input logic [31:0] d);
    a_data = d; a_valid = 1'b1;
    for (int t = 0; t < 50 && !a_ready; t++) @(negedge clk);
    check("a_send_ready", a_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d);
    b_data = d; b_valid = 1'b1;
    for (int t = 0; t < 50 && !b_ready; t++) @(negedge clk);
    check("b_send_ready", b_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    b_valid = 1'b0;
  endtask

  // One full round on the 8-bit loader. mode: 0 result_valid, 1 deadlock, 2 both.
  task automatic b_round(input logic [7:0] tid, input logic [17:0] vec, input logic [5:0] junk,
                         input int gapmax, input int mode, input int waitc);
    logic [7:0] w [3];
    int exp_cnt;
    w[0] = vec[7:0];
    w[1] = vec[15:8];
    w[2] = {junk, vec[17:16]};
    exp_cnt = $countones(vec);
    b_send(tid);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      b_send(w[i]);
    end
    check("b_vec", b_vec, vec);
    check("b_cnt", b_cnt, exp_cnt);
    check("b_tid", b_tid, {24'd0, tid});
`ifdef SYNDROME_LOADER_ZERO_SKIP_EN
    if (exp_cnt == 0) begin
      check("b_zs_done", b_done, 1'b1);
      check("b_zs_nrs", b_nrs, 1'b0);
      check("b_zs_dlk", b_dlk, 1'b0);
      @(negedge clk);
      check("b_zs_idle_ready", b_ready, 1'b1);
      return;
    end
`endif
    check("b_nrs", b_nrs, 1'b1);
    check("b_busy_start", b_busy, 1'b1);
    check("b_ready_start", b_ready, 1'b0);
    @(negedge clk);
    check("b_nrs_once", b_nrs, 1'b0);
    repeat (waitc) @(negedge clk);
    check("b_no_early_done", b_done, 1'b0);
    b_rv = (mode != 1);
    b_dl = (mode != 0);
    @(negedge clk);
    check("b_done", b_done, 1'b1);
    check("b_dlk", b_dlk, mode != 0);
    check("b_busy_done", b_busy, 1'b0);
    check("b_vec_held", b_vec, vec);
    b_rv = 1'b0; b_dl = 1'b0;
    @(negedge clk);
    check("b_done_once", b_done, 1'b0);
    check("b_ready_after", b_ready, 1'b1);
  endtask

  typedef struct {
    logic [31:0] tid;
    logic [31:0] pay;
    logic [17:0] vec;
    logic [15:0] cnt;
    logic        dl;
  } avec_t;

  initial begin #2000000; $display("FAIL watchdog: simulation time limit"); $fatal(1); end

  initial begin
    avec_t tab [4];
    logic [17:0] rv;
    tab[0] = '{32'h0000_0005, 32'h0003_0005, 18'h30005, 16'd4,  1'b0};
    tab[1] = '{32'hABCD_1234, 32'hFFFF_FFFF, 18'h3FFFF, 16'd18, 1'b1};
    tab[2] = '{32'h0000_0002, 32'h0002_AAAA, 18'h2AAAA, 16'd9,  1'b0};
    tab[3] = '{32'h0000_0001, 32'hFFFC_0000, 18'h00000, 16'd0,  1'b0};

    reset_n = 1'b0;
    a_data = '0; a_valid = 1'b0; a_rv = 1'b0; a_dl = 1'b0;
    b_data = '0; b_valid = 1'b0; b_rv = 1'b0; b_dl = 1'b0;
    #12;
    check("reset_outs_a", {a_ready, a_vec, a_nrs, a_done, a_dlk, a_tid, a_cnt, a_busy}, '0);
    check("reset_outs_b", {b_ready, b_vec, b_nrs, b_done, b_dlk, b_tid, b_cnt, b_busy}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven single-word rounds on the 32-bit loader.
    for (int i = 0; i < 4; i++) begin
      a_send(tab[i].tid);
      a_send(tab[i].pay);
      check("a_vec", a_vec, tab[i].vec);
      check("a_cnt", a_cnt, tab[i].cnt);
      check("a_tid", a_tid, tab[i].tid);
`ifdef SYNDROME_LOADER_ZERO_SKIP_EN
      if (tab[i].cnt == 0) begin
        check("a_zs_done", a_done, 1'b1);
        check("a_zs_nrs", a_nrs, 1'b0);
        @(negedge clk);
        continue;
      end
`endif
      check("a_nrs", a_nrs, 1'b1);
      @(negedge clk);
      check("a_nrs_once", a_nrs, 1'b0);
      check("a_busy", a_busy, 1'b1);
      a_rv = !tab[i].dl;
      a_dl = tab[i].dl;
      @(negedge clk);
      check("a_done", a_done, 1'b1);
      check("a_dlk", a_dlk, tab[i].dl);
      a_rv = 1'b0; a_dl = 1'b0;
      @(negedge clk);
      check("a_done_once", a_done, 1'b0);
      check("a_ready_after", a_ready, 1'b1);
      check("a_vec_after", a_vec, tab[i].vec);
    end

    // All ones with padding bits set: padding ignored and not counted.
    b_round(8'h22, 18'h3FFFF, 6'h3F, 0, 0, 1);
    // Simultaneous result_valid and deadlock.
    b_round(8'h44, 18'h0A5A5, 6'h00, 0, 2, 0);
    // Deadlock alone, with stalls between words.
    b_round(8'h45, 18'h10001, 6'h15, 3, 1, 2);
    // All-zero round.
    b_round(8'h60, 18'h00000, 6'h3F, 0, 0, 1);

    // result_valid left high from the previous round.
    b_send(8'h31); b_send(8'h01); b_send(8'h00); b_send(8'h00);
    check("held_nrs1", b_nrs, 1'b1);
    @(negedge clk);
    b_rv = 1'b1;
    @(negedge clk);
    check("held_done1", b_done, 1'b1);
    @(negedge clk);
    b_send(8'h32); b_send(8'h02); b_send(8'h00); b_send(8'h00);
    check("held_nrs2", b_nrs, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("held_no_done", b_done, 1'b0);
    end
    b_rv = 1'b0;
    @(negedge clk);
    check("held_low_no_done", b_done, 1'b0);
    b_rv = 1'b1;
    @(negedge clk);
    check("held_done2", b_done, 1'b1);
    check("held_dlk2", b_dlk, 1'b0);
    b_rv = 1'b0;
    @(negedge clk);

    // Reset after one of three payload words.
    b_send(8'h40); b_send(8'hFF);
    check("mid_busy", b_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("mid_reset_outs", {b_ready, b_vec, b_nrs, b_done, b_dlk, b_tid, b_cnt, b_busy}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    b_round(8'h41, 18'h2C003, 6'h2A, 0, 0, 0);

    // Randomized rounds built from (i,j,k) syndrome coordinates.
    for (int r = 0; r < 30; r++) begin
      rv = '0;
      repeat ($urandom_range(0, 7))
        rv[index_of($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 2), 3, 2)] = 1'b1;
      b_round(8'($urandom), rv, 6'($urandom), 2, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
